// File: rtl/vga_clock_timekeeper.sv
// vga_clock_timekeeper: 1 Hz time-of-day counter with adjust inputs, alarm FSM and buzzer tone.
module vga_clock_timekeeper #(
   parameter int CLK_HZ      = 31500000,
   parameter int HOUR_MODE   = 12,
   parameter int BUZZ_HZ     = 3150,
   parameter int RING_SECS   = 60,
   parameter int SNOOZE_MINS = 5
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       hr_inc,
   input  logic       min_inc,
   input  logic       sec_zero,
   input  logic       al_hr_inc,
   input  logic       al_min_inc,
   input  logic       al_toggle,
   input  logic       snooze,
   output logic [4:0] hours,
   output logic [5:0] minutes,
   output logic [5:0] seconds,
   output logic [4:0] al_hours,
   output logic [5:0] al_minutes,
   output logic       al_on,
   output logic       ringing,
   output logic       buzzer_out,
   output logic       sec_pulse
);
   localparam int PW   = $clog2(CLK_HZ + 1);
   localparam int HALF = (CLK_HZ / (2 * BUZZ_HZ)) < 1 ? 1 : CLK_HZ / (2 * BUZZ_HZ);
   localparam int TW   = $clog2(HALF + 1);
   localparam int RW   = $clog2(RING_SECS + 1);
   localparam int SN   = SNOOZE_MINS * 60;
   localparam int SW   = $clog2(SN + 1);

   typedef enum logic [1:0] {S_IDLE, S_RING, S_SNOOZE} state_t;

   state_t        st_q, st_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [TW-1:0] tone_q, tone_d;
   logic [RW-1:0] rc_q, rc_d;
   logic [SW-1:0] sn_q, sn_d;
   logic [4:0]    hr_q, hr_d, ahr_q, ahr_d;
   logic [5:0]    min_q, min_d, sec_q, sec_d, amin_q, amin_d;
   logic          pulse_q, pulse_d, pend_q, pend_d, al_on_q, al_on_d;
   logic          match_q, match, buz_q, buz_d;
   logic          adj, adv, sec_wrap, min_wrap, hr_wrap, min_step, hr_step;
   logic          ring_stay, tone_wrap;

   // pulse_q mirrors presc_q == CLK_HZ-1, so it doubles as the wrap condition
   assign presc_d  = (sec_zero || pulse_q) ? '0 : presc_q + 1'b1;
   assign pulse_d  = presc_d == PW'(CLK_HZ - 1);
   assign adj      = hr_inc | min_inc | sec_zero;
   assign adv      = !adj && (pulse_q || pend_q);
   assign pend_d   = adj && (pulse_q || pend_q) && !sec_zero;
   assign sec_wrap = sec_q == 6'd59;
   assign min_wrap = min_q == 6'd59;
   assign hr_wrap  = hr_q == 5'(HOUR_MODE - 1);
   assign min_step = min_inc || (adv && sec_wrap);
   assign hr_step  = hr_inc || (adv && sec_wrap && min_wrap);
   assign sec_d    = sec_zero ? '0 : adv ? (sec_wrap ? '0 : sec_q + 1'b1) : sec_q;
   assign min_d    = min_step ? (min_wrap ? '0 : min_q + 1'b1) : min_q;
   assign hr_d     = hr_step ? (hr_wrap ? '0 : hr_q + 1'b1) : hr_q;
   assign ahr_d    = al_hr_inc ? (ahr_q == 5'(HOUR_MODE - 1) ? '0 : ahr_q + 1'b1) : ahr_q;
   assign amin_d   = al_min_inc ? (amin_q == 6'd59 ? '0 : amin_q + 1'b1) : amin_q;
   assign al_on_d  = al_on_q ^ al_toggle;
   assign match    = al_on_q && hr_q == ahr_q && min_q == amin_q && sec_q == '0;

   always_comb begin
      st_d = st_q;
      rc_d = rc_q;
      sn_d = sn_q;
      if (al_toggle)
         st_d = S_IDLE;
      else
         case (st_q)
            S_IDLE:
               if (match && !match_q) begin
                  st_d = S_RING;
                  rc_d = '0;
               end
            S_RING:
               if (snooze) begin
                  st_d = S_SNOOZE;
                  sn_d = SW'(SN);
               end else if (pulse_q) begin
                  rc_d = rc_q + 1'b1;
                  st_d = rc_q == RW'(RING_SECS - 1) ? S_IDLE : S_RING;
               end
            S_SNOOZE:
               if (pulse_q) begin
                  sn_d = sn_q - 1'b1;
                  if (sn_q == SW'(1)) begin
                     st_d = S_RING;
                     rc_d = '0;
                  end
               end
            default: st_d = S_IDLE;
         endcase
   end

   // tone restarts from zero on every entry into RING
   assign ring_stay = st_q == S_RING && st_d == S_RING;
   assign tone_wrap = tone_q == TW'(HALF - 1);
   assign tone_d    = (!ring_stay || tone_wrap) ? '0 : tone_q + 1'b1;
   assign buz_d     = ring_stay && (buz_q ^ tone_wrap);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st_q    <= S_IDLE;
         presc_q <= '0;
         pulse_q <= 1'b0;
         pend_q  <= 1'b0;
         sec_q   <= '0;
         min_q   <= '0;
         hr_q    <= '0;
         ahr_q   <= '0;
         amin_q  <= '0;
         al_on_q <= 1'b0;
         match_q <= 1'b0;
         rc_q    <= '0;
         sn_q    <= '0;
         tone_q  <= '0;
         buz_q   <= 1'b0;
      end else begin
         st_q    <= st_d;
         presc_q <= presc_d;
         pulse_q <= pulse_d;
         pend_q  <= pend_d;
         sec_q   <= sec_d;
         min_q   <= min_d;
         hr_q    <= hr_d;
         ahr_q   <= ahr_d;
         amin_q  <= amin_d;
         al_on_q <= al_on_d;
         match_q <= match;
         rc_q    <= rc_d;
         sn_q    <= sn_d;
         tone_q  <= tone_d;
         buz_q   <= buz_d;
      end
   end

   assign hours      = hr_q;
   assign minutes    = min_q;
   assign seconds    = sec_q;
   assign al_hours   = ahr_q;
   assign al_minutes = amin_q;
   assign al_on      = al_on_q;
   assign ringing    = st_q == S_RING;
   assign buzzer_out = buz_q;
   assign sec_pulse  = pulse_q;
endmodule

// File: tb/tb_vga_clock_timekeeper.sv
// tb_vga_clock_timekeeper: 12h and 24h instances on shared stimulus, checked against a time-of-day model.
module tb_vga_clock_timekeeper;
   localparam int C = 10, BZ = 1, RS = 3, SM = 1, HALF = 5;
   localparam logic [6:0] P_HR = 7'h40, P_MI = 7'h20, P_SZ = 7'h10, P_AH = 7'h08;
   localparam logic [6:0] P_AM = 7'h04, P_AT = 7'h02, P_SN = 7'h01;

   logic clk = 1'b0, reset_n = 1'b1;
   logic hr_inc = 0, min_inc = 0, sec_zero = 0, al_hr_inc = 0, al_min_inc = 0, al_toggle = 0, snooze = 0;
   logic [4:0] hours[2], al_hours[2];
   logic [5:0] minutes[2], seconds[2], al_minutes[2];
   logic al_on[2], ringing[2], buzzer_out[2], sec_pulse[2];
   logic [6:0] in_q = '0;
   logic rq = 1'b0;
   int cmp = 0, mis = 0, n;
   int mh[2], mm[2], ms[2], mah[2], mam[2], mpr[2], mst[2], mrc[2], msn[2], mk[2];
   bit mpend[2], mon[2], mmatch[2];

   always #5 clk = ~clk;

   vga_clock_timekeeper #(.CLK_HZ(C), .HOUR_MODE(12), .BUZZ_HZ(BZ), .RING_SECS(RS), .SNOOZE_MINS(SM)) u12 (
      .clk(clk), .reset_n(reset_n), .hr_inc(hr_inc), .min_inc(min_inc), .sec_zero(sec_zero),
      .al_hr_inc(al_hr_inc), .al_min_inc(al_min_inc), .al_toggle(al_toggle), .snooze(snooze),
      .hours(hours[0]), .minutes(minutes[0]), .seconds(seconds[0]), .al_hours(al_hours[0]),
      .al_minutes(al_minutes[0]), .al_on(al_on[0]), .ringing(ringing[0]), .buzzer_out(buzzer_out[0]),
      .sec_pulse(sec_pulse[0]));

   vga_clock_timekeeper #(.CLK_HZ(C), .HOUR_MODE(24), .BUZZ_HZ(BZ), .RING_SECS(RS), .SNOOZE_MINS(SM)) u24 (
      .clk(clk), .reset_n(reset_n), .hr_inc(hr_inc), .min_inc(min_inc), .sec_zero(sec_zero),
      .al_hr_inc(al_hr_inc), .al_min_inc(al_min_inc), .al_toggle(al_toggle), .snooze(snooze),
      .hours(hours[1]), .minutes(minutes[1]), .seconds(seconds[1]), .al_hours(al_hours[1]),
      .al_minutes(al_minutes[1]), .al_on(al_on[1]), .ringing(ringing[1]), .buzzer_out(buzzer_out[1]),
      .sec_pulse(sec_pulse[1]));

   task automatic chk(input string name, input int i, input int a, input int e);
      cmp++;
      if (a !== e) begin
         mis++;
         $display("FAIL %s[%0d]: got %0d expected %0d at %0t", name, i, a, e, $time);
      end
   endtask

   task automatic model_reset(input int i);
      mh[i] = 0; mm[i] = 0; ms[i] = 0; mah[i] = 0; mam[i] = 0; mpr[i] = 0;
      mst[i] = 0; mrc[i] = 0; msn[i] = 0; mk[i] = 0; mpend[i] = 0; mon[i] = 0; mmatch[i] = 0;
   endtask

   // states: 0 idle, 1 ringing, 2 snoozing; time kept as seconds-of-day arithmetic
   task automatic step(input int i);
      int hm, tod;
      bit tick, adj, match, was;
      logic hi, mi, sz, ah, am, at, sn;
      {hi, mi, sz, ah, am, at, sn} = in_q;
      hm = i ? 24 : 12;
      tick = mpr[i] == C - 1;
      adj = hi | mi | sz;
      match = mon[i] && mh[i] == mah[i] && mm[i] == mam[i] && ms[i] == 0;
      was = mst[i] == 1;
      mpr[i] = sz ? 0 : (mpr[i] + 1) % C;
      if (adj) begin
         if (hi) mh[i] = (mh[i] + 1) % hm;
         if (mi) mm[i] = (mm[i] + 1) % 60;
         if (sz) ms[i] = 0;
         mpend[i] = (tick || mpend[i]) && !sz;
      end else if (tick || mpend[i]) begin
         tod = ((mh[i] * 60 + mm[i]) * 60 + ms[i] + 1) % (hm * 3600);
         mh[i] = tod / 3600; mm[i] = (tod / 60) % 60; ms[i] = tod % 60;
         mpend[i] = 0;
      end
      if (ah) mah[i] = (mah[i] + 1) % hm;
      if (am) mam[i] = (mam[i] + 1) % 60;
      if (at) mst[i] = 0;
      else if (mst[i] == 0) begin
         if (match && !mmatch[i]) begin mst[i] = 1; mrc[i] = 0; end
      end else if (mst[i] == 1) begin
         if (sn) begin mst[i] = 2; msn[i] = SM * 60; end
         else if (tick) begin mrc[i]++; if (mrc[i] == RS) mst[i] = 0; end
      end else if (tick) begin
         msn[i]--;
         if (msn[i] == 0) begin mst[i] = 1; mrc[i] = 0; end
      end
      mon[i] = mon[i] ^ at;
      mmatch[i] = match;
      mk[i] = (was && mst[i] == 1) ? mk[i] + 1 : 0;
   endtask

   always @(posedge clk) begin
      in_q <= {hr_inc, min_inc, sec_zero, al_hr_inc, al_min_inc, al_toggle, snooze};
      rq <= reset_n;
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!reset_n || !rq) model_reset(i);
         else step(i);
         chk("hours", i, hours[i], mh[i]);
         chk("minutes", i, minutes[i], mm[i]);
         chk("seconds", i, seconds[i], ms[i]);
         chk("al_hours", i, al_hours[i], mah[i]);
         chk("al_minutes", i, al_minutes[i], mam[i]);
         chk("al_on", i, al_on[i], mon[i]);
         chk("ringing", i, ringing[i], mst[i] == 1);
         chk("buzzer", i, buzzer_out[i], mst[i] == 1 && (mk[i] / HALF) % 2 == 1);
         chk("sec_pulse", i, sec_pulse[i], mpr[i] == C - 1);
      end
   end

   task automatic drive(input logic [6:0] v, input int cnt);
      repeat (cnt) begin
         {hr_inc, min_inc, sec_zero, al_hr_inc, al_min_inc, al_toggle, snooze} = v;
         @(negedge clk);
      end
      {hr_inc, min_inc, sec_zero, al_hr_inc, al_min_inc, al_toggle, snooze} = '0;
   endtask

   task automatic wait_ring(input logic v, input int maxc, output int cnt);
      cnt = 0;
      while (ringing[0] !== v && cnt < maxc) begin
         @(negedge clk);
         cnt++;
      end
   endtask

   task automatic first_pulse();
      int c = 0;
      while (sec_pulse[0] !== 1'b1 && c < 20) begin
         @(negedge clk);
         c++;
      end
      chk("first_pulse_cycle", 0, c, 9);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_hours", 0, hours[0], 0);
      chk("rst_ringing", 1, ringing[1], 0);
      #2 reset_n = 1'b1;
      first_pulse();
      drive(P_SZ, 1);
      drive(P_HR, 23);
      drive(P_MI, 59);
      drive(P_SZ, 1);
      repeat (599) @(negedge clk);
      chk("pre_h12", 0, hours[0], 11);
      chk("pre_h24", 1, hours[1], 23);
      chk("pre_min", 0, minutes[0], 59);
      chk("pre_sec", 1, seconds[1], 59);
      chk("pre_pulse", 0, sec_pulse[0], 1);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("roll_h", i, hours[i], 0);
         chk("roll_m", i, minutes[i], 0);
         chk("roll_s", i, seconds[i], 0);
      end
      drive(P_MI, 60);
      chk("wrap_min", 0, minutes[0], 0);
      chk("wrap_hr", 0, hours[0], 0);
      drive(P_AM, 59);
      chk("al_min59", 0, al_minutes[0], 59);
      drive(P_AM, 1);
      chk("al_wrap_min", 0, al_minutes[0], 0);
      chk("al_wrap_hr", 0, al_hours[0], 0);
      drive(P_SZ, 1);
      repeat (599) @(negedge clk);
      drive(P_MI, 1);
      chk("coll_min", 0, minutes[0], 1);
      chk("coll_sec", 0, seconds[0], 59);
      @(negedge clk);
      chk("coll_min2", 0, minutes[0], 2);
      chk("coll_sec2", 0, seconds[0], 0);
      drive(P_SZ, 1);
      repeat (599) @(negedge clk);
      drive(P_SZ, 1);
      chk("sz_min", 0, minutes[0], 2);
      chk("sz_sec", 0, seconds[0], 0);
      @(negedge clk);
      chk("sz_min_next", 1, minutes[1], 2);
      chk("sz_sec_next", 1, seconds[1], 0);
      drive(P_AM, 3);
      drive(P_AT, 1);
      chk("al_on_set", 0, al_on[0], 1);
      wait_ring(1'b1, 800, n);
      chk("ringA_seen", 0, n < 800, 1);
      chk("ringA_min", 0, minutes[0], 3);
      chk("ringA_sec", 0, seconds[0], 0);
      repeat (4) @(negedge clk);
      chk("buzz_k4", 0, buzzer_out[0], 0);
      @(negedge clk);
      chk("buzz_k5", 0, buzzer_out[0], 1);
      wait_ring(1'b0, 100, n);
      chk("ringA_end", 0, n < 100, 1);
      chk("ringA_end_sec", 0, seconds[0], 3);
      chk("ringA_end_buzz", 0, buzzer_out[0], 0);
      drive(P_AM, 1);
      wait_ring(1'b1, 800, n);
      chk("ringB_seen", 0, n < 800, 1);
      drive(P_SN, 1);
      chk("snooze_quiet", 0, ringing[0], 0);
      wait_ring(1'b1, 700, n);
      chk("snooze_len", 0, n, 598);
      drive(P_SN, 1);
      repeat (50) @(negedge clk);
      drive(P_AT, 1);
      chk("toggle_off", 0, al_on[0], 0);
      repeat (700) @(negedge clk);
      chk("no_ring", 0, ringing[0], 0);
      chk("no_ring", 1, ringing[1], 0);
      drive(P_AM, 3);
      drive(P_AT, 1);
      wait_ring(1'b1, 900, n);
      chk("ringC_seen", 0, n < 900, 1);
      repeat (7) @(negedge clk);
      chk("ringC_buzz", 0, buzzer_out[0], 1);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("mid_rst_ring", i, ringing[i], 0);
         chk("mid_rst_buzz", i, buzzer_out[i], 0);
         chk("mid_rst_alon", i, al_on[i], 0);
         chk("mid_rst_min", i, minutes[i], 0);
         chk("mid_rst_almin", i, al_minutes[i], 0);
      end
      @(negedge clk);
      #2 reset_n = 1'b1;
      first_pulse();
      for (int c = 0; c < 4000; c++) begin
         {hr_inc, min_inc, sec_zero, al_hr_inc, al_min_inc, al_toggle, snooze} =
            {$urandom_range(39) == 0, $urandom_range(39) == 0, $urandom_range(59) == 0,
             $urandom_range(29) == 0, $urandom_range(29) == 0, $urandom_range(149) == 0,
             $urandom_range(19) == 0};
         @(negedge clk);
      end
      drive(7'h00, 2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
      $finish;
   end
endmodule
